// File: rtl/seg8_pkg.sv
// seg8_pkg: segment patterns, digit count and FSM state codes shared by the
// 8-segment display driver and the capture side.
package seg8_pkg;
   localparam int DIGITS = 4;
   localparam logic [6:0] SEG_0 = 7'h3F, SEG_1 = 7'h06, SEG_2 = 7'h5B, SEG_3 = 7'h4F,
                          SEG_4 = 7'h66, SEG_5 = 7'h6D, SEG_6 = 7'h7D, SEG_7 = 7'h07,
                          SEG_8 = 7'h7F, SEG_9 = 7'h6F, SEG_A = 7'h77, SEG_B = 7'h7C,
                          SEG_C = 7'h39, SEG_D = 7'h5E, SEG_E = 7'h79, SEG_F = 7'h71;
   localparam logic [15:0][6:0] SEG_TABLE = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                             SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
   typedef logic [1:0] state_t;
   localparam state_t SYNC = 2'd0, COLLECT = 2'd1, OUT = 2'd2;
   // index of the set bit in a one-hot digit select
   function automatic logic [1:0] oh_index(input logic [3:0] oh);
      return {oh[3] | oh[2], oh[3] | oh[1]};
   endfunction
endpackage

// File: rtl/seg8_capture_if.sv
// seg8_capture_if: display bus in, rebuilt word and status out.
interface seg8_capture_if;
   logic [3:0]  drains;
   logic [7:0]  leds;
   logic [19:0] data;
   logic        data_valid;
   logic        seg_err;
   logic        blanked;
   modport master (output drains, leds, input data, data_valid, seg_err, blanked);
   modport slave (input drains, leds, output data, data_valid, seg_err, blanked);
endinterface

// File: rtl/seg8_to_nibble.sv
// seg8_to_nibble: inverse 7-segment decode; o_valid low for patterns outside 0..F.
module seg8_to_nibble
   import seg8_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_nibble,
   output logic       o_valid
);
   always_comb begin
      o_nibble = '0;
      o_valid  = 1'b0;
      for (int k = 0; k < 16; k++)
         if (i_seg == SEG_TABLE[k]) begin
            o_nibble = 4'(k);
            o_valid  = 1'b1;
         end
   end
endmodule

// File: rtl/seg8_capture.sv
// seg8_capture: snoops a 4-digit multiplexed display bus and rebuilds the
// {dots, hex} word it is showing, flagging protocol and pattern errors.
module seg8_capture
   import seg8_pkg::*;
#(
   parameter int HOLD_CYCLES = 1,
   parameter bit CHECK_ORDER = 1
) (
   input logic           clock,
   input logic           reset_n,
   seg8_capture_if.slave bus
);
   localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);
   logic [3:0]              r_drains, r_cnt, r_mask;
   logic [7:0]              r_leds;
   logic                    r_fresh, r_blanked, r_valid, r_err;
   state_t                  r_state;
   logic [DIGITS-1:0][4:0]  r_slot;
   logic [19:0]             r_data, w_word;
   logic [3:0]              w_nib, w_cnt_nx, w_mask_nx;
   logic [1:0]              w_idx, w_next;
   logic                    w_seg_ok, w_same, w_blank, w_onehot, w_collect, w_start;
   logic                    w_order_err, w_err, w_take, w_done;
   seg8_to_nibble u_dec (.i_seg(r_leds[6:0]), .o_nibble(w_nib), .o_valid(w_seg_ok));
   // hold filter runs on the incoming sample so its acceptance pulse lines up with the stage-1 regs
   assign w_same    = {bus.drains, bus.leds} == {r_drains, r_leds};
   assign w_cnt_nx  = !w_same ? 4'd1 : (r_cnt == HOLD) ? HOLD : r_cnt + 4'd1;
   assign w_blank   = r_drains == 4'd0;
   assign w_onehot  = !w_blank && ((r_drains & (r_drains - 4'd1)) == 4'd0);
   assign w_idx     = oh_index(r_drains);
   assign w_next    = 2'($countones(r_mask));
   assign w_collect = r_state == COLLECT;
   assign w_start   = w_onehot && (w_idx == 2'd0 || (!CHECK_ORDER && r_state == OUT));
   assign w_order_err = CHECK_ORDER ? (w_idx != w_next) : r_mask[w_idx];
   assign w_err     = r_fresh && !w_blank &&
                      (!w_onehot || ((w_collect || w_start) && (!w_seg_ok || (w_collect && w_order_err))));
   assign w_take    = r_fresh && w_onehot && !w_err && (w_collect || w_start);
   assign w_mask_nx = (w_collect ? r_mask : 4'd0) | (4'b1 << w_idx);
   assign w_done    = w_take && w_mask_nx == 4'hF;
   always_comb begin
      w_word = '0;
      for (int k = 0; k < DIGITS; k++) begin
         w_word[16+k]  = (w_idx == 2'(k)) ? r_leds[7] : r_slot[k][4];
         w_word[4*k+:4] = (w_idx == 2'(k)) ? w_nib : r_slot[k][3:0];
      end
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_drains  <= '0;
         r_leds    <= '0;
         r_cnt     <= '0;
         r_fresh   <= 1'b0;
         r_blanked <= 1'b0;
         r_state   <= SYNC;
         r_mask    <= '0;
         r_slot    <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_drains  <= bus.drains;
         r_leds    <= bus.leds;
         r_cnt     <= w_cnt_nx;
         r_fresh   <= (w_cnt_nx == HOLD) && !(w_same && r_cnt == HOLD);
         r_blanked <= bus.drains == 4'd0;
         r_err     <= w_err;
         r_valid   <= w_done;
         r_state   <= (w_err || w_blank) ? SYNC : w_done ? OUT : (w_take || w_collect) ? COLLECT : SYNC;
         r_mask    <= (w_take && !w_done) ? w_mask_nx : (w_collect && !w_blank && !w_err) ? r_mask : 4'd0;
         if (w_take) r_slot[w_idx] <= {r_leds[7], w_nib};
         if (w_done) r_data <= w_word;
      end
   end
   assign bus.data       = r_data;
   assign bus.data_valid = r_valid;
   assign bus.seg_err    = r_err;
   assign bus.blanked    = r_blanked;
endmodule

// File: tb/tb_seg8_capture.sv
// tb_seg8_capture: per-cycle vector table on a HOLD_CYCLES=1 instance plus
// hand-written hold-filter sequences on a HOLD_CYCLES=3 instance.
module tb_seg8_capture;
   typedef struct {
      logic        rn;
      logic [3:0]  dr;
      logic [7:0]  ld;
      logic        ev, ee, eb;
      logic [19:0] ed;
   } vec_t;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0, errors = 0, step = 0;
   int   bv, be, bstep, t3;
   vec_t vecs[$];
   always #5 clock = ~clock;
   seg8_capture_if ia ();
   seg8_capture_if ib ();
   seg8_capture #(.HOLD_CYCLES(1), .CHECK_ORDER(1)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ia));
   seg8_capture #(.HOLD_CYCLES(3), .CHECK_ORDER(1)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ib));
   task automatic add(input logic rn, input logic [3:0] dr, input logic [7:0] ld,
                      input logic ev, input logic ee, input logic eb, input logic [19:0] ed);
      vec_t v;
      v.rn = rn; v.dr = dr; v.ld = ld; v.ev = ev; v.ee = ee; v.eb = eb; v.ed = ed;
      vecs.push_back(v);
   endtask
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask
   task automatic drive_b(input logic [3:0] dr, input logic [7:0] ld, input int n);
      repeat (n) begin
         @(negedge clock);
         step++;
         if (ib.data_valid) begin
            bv++;
            bstep = step;
         end
         if (ib.seg_err) be++;
         ib.drains = dr;
         ib.leds   = ld;
      end
   endtask
   initial begin
      ia.drains = '0; ia.leds = '0; ib.drains = '0; ib.leds = '0;
      // outputs in row k reflect inputs of row k-1 (blanked) and row k-2 (valid/err/data)
      add(0, 4'h0, 8'h00, 0, 0, 0, 20'h00000);
      add(1, 4'h0, 8'h00, 0, 0, 0, 20'h00000);
      add(1, 4'h1, 8'h86, 0, 0, 1, 20'h00000);
      add(1, 4'h2, 8'h39, 0, 0, 0, 20'h00000);
      add(1, 4'h4, 8'hCF, 0, 0, 0, 20'h00000);
      add(1, 4'h8, 8'h77, 0, 0, 0, 20'h00000);
      add(1, 4'h1, 8'h86, 0, 0, 0, 20'h00000);
      add(1, 4'h2, 8'h39, 1, 0, 0, 20'h5A3C1);
      add(1, 4'h4, 8'hCF, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h8, 8'h77, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h1, 8'h86, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h2, 8'h39, 1, 0, 0, 20'h5A3C1);
      add(1, 4'h1, 8'h00, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h1, 8'h00, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h0, 8'h00, 0, 1, 0, 20'h5A3C1);
      add(1, 4'h1, 8'h86, 0, 0, 1, 20'h5A3C1);
      add(1, 4'h4, 8'hCF, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h1, 8'h07, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h2, 8'h7F, 0, 1, 0, 20'h5A3C1);
      add(1, 4'h4, 8'hEF, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h8, 8'h71, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h0, 8'h00, 0, 0, 0, 20'h5A3C1);
      add(1, 4'h0, 8'h00, 1, 0, 1, 20'h4F987);
      add(1, 4'h1, 8'h3F, 0, 0, 1, 20'h4F987);
      add(1, 4'h3, 8'h06, 0, 0, 0, 20'h4F987);
      add(1, 4'h0, 8'h00, 0, 0, 0, 20'h4F987);
      add(1, 4'h1, 8'h3F, 0, 1, 1, 20'h4F987);
      add(1, 4'h2, 8'h06, 0, 0, 0, 20'h4F987);
      add(1, 4'h0, 8'h00, 0, 0, 0, 20'h4F987);
      add(1, 4'h4, 8'h5B, 0, 0, 1, 20'h4F987);
      add(1, 4'h8, 8'h4F, 0, 0, 0, 20'h4F987);
      add(1, 4'h0, 8'h00, 0, 0, 0, 20'h4F987);
      add(1, 4'h0, 8'h00, 0, 0, 1, 20'h4F987);
      add(1, 4'h1, 8'h3F, 0, 0, 1, 20'h4F987);
      add(1, 4'h2, 8'h06, 0, 0, 0, 20'h4F987);
      add(0, 4'h4, 8'h5B, 0, 0, 0, 20'h4F987);
      add(1, 4'h4, 8'h5B, 0, 0, 0, 20'h00000);
      add(1, 4'h8, 8'h4F, 0, 0, 0, 20'h00000);
      add(1, 4'h0, 8'h00, 0, 0, 0, 20'h00000);
      add(1, 4'h0, 8'h00, 0, 0, 1, 20'h00000);
      add(1, 4'h1, 8'h00, 0, 0, 1, 20'h00000);
      add(1, 4'h0, 8'h00, 0, 0, 0, 20'h00000);
      add(1, 4'h0, 8'h00, 0, 1, 1, 20'h00000);
      foreach (vecs[k]) begin
         @(negedge clock);
         step++;
         checks++;
         if ({ia.data_valid, ia.seg_err, ia.blanked, ia.data} !== {vecs[k].ev, vecs[k].ee, vecs[k].eb, vecs[k].ed}) begin
            errors++;
            $display("FAIL vec%0d: got v=%b e=%b b=%b data=%h, want v=%b e=%b b=%b data=%h", k,
                     ia.data_valid, ia.seg_err, ia.blanked, ia.data,
                     vecs[k].ev, vecs[k].ee, vecs[k].eb, vecs[k].ed);
         end
         reset_n   = vecs[k].rn;
         ia.drains = vecs[k].dr;
         ia.leds   = vecs[k].ld;
      end
      // HOLD_CYCLES=3: 3-cycle digits with a 1-cycle multi-hot glitch between digits 0 and 1
      bv = 0; be = 0; bstep = -1;
      drive_b(4'h1, 8'h86, 3);
      drive_b(4'h3, 8'h06, 1);
      drive_b(4'h2, 8'h39, 3);
      drive_b(4'h4, 8'hCF, 3);
      t3 = step + 1;
      drive_b(4'h8, 8'h77, 3);
      drive_b(4'h0, 8'h00, 4);
      check("hold3_valid_count", 32'(bv), 32'd1);
      check("hold3_err_count", 32'(be), 32'd0);
      check("hold3_latency", 32'(bstep), 32'(t3 + 4));
      check("hold3_data", 32'(ib.data), 32'h5A3C1);
      // digits held one cycle short of the filter length are never accepted
      bv = 0; be = 0;
      drive_b(4'h1, 8'h3F, 2);
      drive_b(4'h2, 8'h06, 2);
      drive_b(4'h4, 8'h5B, 2);
      drive_b(4'h8, 8'h4F, 2);
      drive_b(4'h0, 8'h00, 4);
      check("hold2_valid_count", 32'(bv), 32'd0);
      check("hold2_err_count", 32'(be), 32'd0);
      check("hold2_data_held", 32'(ib.data), 32'h5A3C1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
